ternary_seq_alu: RTL and testbench
==================================

// Module: ternary_seq_alu
// PURPOSE
//  Parametrised multi-cycle ternary ALU; successor to the single-cycle 9-trit ALU.
//  Adds a full signed balanced-ternary multiply (shift-and-add, 2N-trit product), trit-wise MIN/MAX, and valid/ready handshakes.
//  Sits between the stack-machine issue logic and the stack write-back; one operation in flight.
// PARAMETERS
//  N_TRITS   9  word width in trits; bus width = 2*N_TRITS bits
//  TPC       1  multiplier trits consumed per cycle; must divide N_TRITS (elaboration error otherwise)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operation request
//  in_ready   out  1        block idle, can accept
//  op         in   3        000 ADD, 001 SUB, 010 MUL, 011 TMUL, 100 MIN, 101 MAX
//  a          in   2*N      operand A, trit i at [2i+1:2i]
//  b          in   2*N      operand B
//  out_valid  out  1        result held valid
//  out_ready  in   1        consumer accepts result
//  result_lo  out  2*N      low N trits of result
//  result_hi  out  2*N      high N trits (MUL only; all-Z otherwise)
//  carry      out  2        carry trit (ADD/SUB only; Z otherwise)
//  err        out  1        input held encoding 2'b11, or op undefined
// BEHAVIOUR
//  Encoding: 00=Z, 01=P(+1), 10=N(-1); 11 is read as Z and sets err for that operation.
//  Reset (async on rst_n low): state IDLE; out_valid=0, result_lo/hi=0, carry=Z, err=0.
//    in_ready is forced 0 while rst_n is low and is 1 in the first cycle after release.
//    Reset mid-operation aborts the operation; no result is produced.
//  FSM IDLE -> EXEC -> DONE -> IDLE. in_ready = (state==IDLE).
//  Accept: in_valid && in_ready at edge E0. op, a and b are registered; the inputs need not stay stable afterwards.
//  EXEC timing:
//    MUL: S = N_TRITS/TPC cycles.
//    Other ops, including undefined: 1 cycle.
//    DONE is entered and out_valid rises at edge E1 (non-MUL) or E_S (MUL).
//  DONE: outputs stable while out_valid=1 && !out_ready.
//    Handshake (out_valid && out_ready) -> IDLE, out_valid=0. Output registers keep their last values.
//    New accept is possible at the first edge after return to IDLE; no overlap, no bypass.
//  ADD/SUB:
//    Ripple balanced-ternary add of N trits. SUB = a + neg(b), neg swaps P/N.
//    result_lo wraps mod 3^N; carry is the final carry trit (P/N/Z).
//  MUL:
//    Exact signed product in 2N trits. Magnitude is always < (3^(2N)-1)/2, so it never overflows.
//    Per EXEC cycle, TPC trits of b (LSB first) form partial products a*b_k (a, neg(a) or 0).
//    Each partial product is accumulated with the shift for its weight.
//  TMUL/MIN/MAX: trit-wise, no carries. MIN/MAX order N < Z < P.
//  Undefined op: result_lo/hi = 0, carry = Z, err = 1.
// STRUCTURE
//  Package ternary_pkg:
//    trit typedef and T_Z/T_P/T_N constants.
//    op-code localparams.
//    functions trit_neg, trit_to_int, int_to_trit, trit_mul.
//  Sub-module ternary_word_adder_n:
//    parameter W (trits); ports a, b, cin, sum, cout; purely combinational ripple.
//    Used once for ADD/SUB and once (W=N+TPC) for the MUL accumulator.
//  Top holds the FSM, step counter (clog2(S) bits), operand and accumulator registers.
// TESTING (N_TRITS=9 unless noted; values are decimal and encoded in balanced ternary)
//  ADD 13 + 1 -> 14, carry Z, err 0.
//    out_valid rises exactly 1 edge after accept; in_ready low in EXEC and DONE.
//  ADD 9841 + 1 -> -9841 with carry P.
//    SUB -9841 - 1 -> 9841 with carry N.
//  MUL 9841*9841 -> 96845281 across hi:lo; MUL -1*5 -> -5, hi encodes -0 = all Z.
//    out_valid after exactly 9 edges (TPC=1) and 3 edges (TPC=3).
//  Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_valid ignored.
//    Release -> IDLE next edge; back-to-back accept the edge after.
//  Assert rst_n low mid-MUL (step 4) -> out_valid=0 and outputs zero immediately, with no clock.
//    After release: in_ready=1, and a new ADD 2 + 2 returns 4.
//  Operand trit 2'b11 in ADD -> treated as Z, err=1.
//    op 111 -> result 0, err=1.
//    MIN/MAX/TMUL on a=PZN..., b=NPN... -> trit-wise tables match.

Source files
------------

// File: rtl/ternary_pkg.sv
// Balanced-ternary types, op codes and single-trit helpers for the ternary ALU slice.
// Trit encoding: 00 = Z, 01 = P (+1), 10 = N (-1); 11 is illegal and read as Z.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t T_Z = 2'b00;
  localparam trit_t T_P = 2'b01;
  localparam trit_t T_N = 2'b10;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_TMUL = 3'b011;
  localparam logic [2:0] OP_MIN  = 3'b100;
  localparam logic [2:0] OP_MAX  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic trit_t trit_neg(input trit_t t);
    case (t)
      T_P:     return T_N;
      T_N:     return T_P;
      default: return T_Z;
    endcase
  endfunction

  function automatic logic signed [2:0] trit_to_int(input trit_t t);
    case (t)
      T_P:     return 3'sd1;
      T_N:     return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  function automatic trit_t int_to_trit(input logic signed [2:0] v);
    if (v > 3'sd0) begin
      return T_P;
    end else if (v < 3'sd0) begin
      return T_N;
    end else begin
      return T_Z;
    end
  endfunction

  function automatic trit_t trit_mul(input trit_t x, input trit_t y);
    return int_to_trit(trit_to_int(x) * trit_to_int(y));
  endfunction

  function automatic trit_t trit_clean(input trit_t t);
    return (t == 2'b11) ? T_Z : t;
  endfunction

  // Full adder on three trits; returns {carry, sum}. The raw sum lies in -3..+3.
  function automatic logic [3:0] trit_fa(input trit_t x, input trit_t y, input trit_t c);
    logic signed [2:0] s;
    s = trit_to_int(x) + trit_to_int(y) + trit_to_int(c);
    if (s > 3'sd1) begin
      return {T_P, int_to_trit(s - 3'sd3)};
    end else if (s < -3'sd1) begin
      return {T_N, int_to_trit(s + 3'sd3)};
    end else begin
      return {T_Z, int_to_trit(s)};
    end
  endfunction

endpackage

// File: rtl/ternary_word_adder_n.sv
// Combinational ripple-carry adder over W balanced-ternary trits.
module ternary_word_adder_n
  import ternary_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  trit_t          cin,
  output logic [2*W-1:0] sum,
  output trit_t          cout
);

  trit_t      rip_c_s;
  logic [3:0] rip_fa_s;

  // Ripple the carry trit from the least significant trit upwards
  always_comb begin
    sum      = '0;
    rip_c_s  = cin;
    rip_fa_s = 4'b0000;
    for (int i = 0; i < W; i++) begin
      rip_fa_s       = trit_fa(a[2*i +: 2], b[2*i +: 2], rip_c_s);
      sum[2*i +: 2]  = rip_fa_s[1:0];
      rip_c_s        = rip_fa_s[3:2];
    end
    cout = rip_c_s;
  end

endmodule

// File: rtl/ternary_seq_alu.sv
// Multi-cycle balanced-ternary ALU: ADD/SUB, shift-and-add MUL, trit-wise TMUL/MIN/MAX,
// with valid/ready handshakes on both sides and one operation in flight.
module ternary_seq_alu
  import ternary_pkg::*;
#(
  parameter int N_TRITS = 9,
  parameter int TPC     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [2*N_TRITS-1:0] a,
  input  logic [2*N_TRITS-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N_TRITS-1:0] result_lo,
  output logic [2*N_TRITS-1:0] result_hi,
  output logic [1:0]           carry,
  output logic                 err
);

  localparam int S      = N_TRITS / TPC;
  localparam int STEP_W = (S > 1) ? $clog2(S) : 1;
  localparam int W      = 2 * N_TRITS;
  localparam int PW     = 2 * (N_TRITS + TPC);

  if ((TPC < 1) || ((N_TRITS % TPC) != 0)) begin : g_tpc_check
    $error("ternary_seq_alu: TPC must divide N_TRITS");
  end

  state_t             state_r, state_s;
  logic [STEP_W-1:0]  step_r;
  logic [2:0]         op_r;
  logic [W-1:0]       a_r, b_r;
  logic               bad_r;
  logic [W-1:0]       acc_r, lo_r;
  logic               out_valid_r;
  logic [W-1:0]       result_lo_r, result_hi_r;
  trit_t              carry_r;
  logic               err_r;

  logic [W-1:0]       a_clean_s, b_clean_s;
  logic               in_bad_s, op_bad_s;
  logic [W-1:0]       b_add_s, add_sum_s;
  trit_t              add_cout_s;
  logic [W-1:0]       tw_s;
  logic [PW-1:0]      row_s, pp_s, acc_ext_s, mac_sum_s;
  trit_t              pp_c_s, mac_cout_s;
  logic [3:0]         pp_fa_s;
  logic [W-1:0]       mul_lo_next_s, mul_hi_next_s;
  logic               last_step_s;
  logic [W-1:0]       fin_lo_s, fin_hi_s;
  trit_t              fin_carry_s;
  logic               fin_err_s;
  logic               unused_s;

  // Scrub illegal 11 trits to Z at the input and flag them
  always_comb begin
    a_clean_s = '0;
    b_clean_s = '0;
    in_bad_s  = 1'b0;
    for (int i = 0; i < N_TRITS; i++) begin
      a_clean_s[2*i +: 2] = trit_clean(a[2*i +: 2]);
      b_clean_s[2*i +: 2] = trit_clean(b[2*i +: 2]);
      in_bad_s = in_bad_s | (a[2*i +: 2] == 2'b11) | (b[2*i +: 2] == 2'b11);
    end
  end

  assign op_bad_s = (op > OP_MAX);

  // Subtraction is addition of the trit-wise negated operand
  always_comb begin
    b_add_s = '0;
    for (int i = 0; i < N_TRITS; i++) begin
      if (op_r == OP_SUB) begin
        b_add_s[2*i +: 2] = trit_neg(b_r[2*i +: 2]);
      end else begin
        b_add_s[2*i +: 2] = b_r[2*i +: 2];
      end
    end
  end

  ternary_word_adder_n #(.W(N_TRITS)) u_add (
    .a    (a_r),
    .b    (b_add_s),
    .cin  (T_Z),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Carry-free trit-wise operations; MIN/MAX use the order N < Z < P
  always_comb begin
    tw_s = '0;
    for (int i = 0; i < N_TRITS; i++) begin
      case (op_r)
        OP_TMUL: tw_s[2*i +: 2] = trit_mul(a_r[2*i +: 2], b_r[2*i +: 2]);
        OP_MIN:  tw_s[2*i +: 2] = (trit_to_int(a_r[2*i +: 2]) < trit_to_int(b_r[2*i +: 2]))
                                  ? a_r[2*i +: 2] : b_r[2*i +: 2];
        OP_MAX:  tw_s[2*i +: 2] = (trit_to_int(a_r[2*i +: 2]) > trit_to_int(b_r[2*i +: 2]))
                                  ? a_r[2*i +: 2] : b_r[2*i +: 2];
        default: tw_s[2*i +: 2] = T_Z;
      endcase
    end
  end

  // Partial product a * (low TPC trits of b_r), summed into N+TPC trits
  always_comb begin
    pp_s    = '0;
    row_s   = '0;
    pp_c_s  = T_Z;
    pp_fa_s = 4'b0000;
    for (int t = 0; t < TPC; t++) begin
      row_s = '0;
      for (int i = 0; i < N_TRITS; i++) begin
        row_s[2*(i+t) +: 2] = trit_mul(a_r[2*i +: 2], b_r[2*t +: 2]);
      end
      pp_c_s = T_Z;
      for (int i = 0; i < N_TRITS + TPC; i++) begin
        pp_fa_s        = trit_fa(pp_s[2*i +: 2], row_s[2*i +: 2], pp_c_s);
        pp_s[2*i +: 2] = pp_fa_s[1:0];
        pp_c_s         = pp_fa_s[3:2];
      end
    end
  end

  // acc_r holds the upper N trits of the running product; it always fits, so no carry-out
  assign acc_ext_s = {{(2*TPC){1'b0}}, acc_r};

  ternary_word_adder_n #(.W(N_TRITS + TPC)) u_mac (
    .a    (acc_ext_s),
    .b    (pp_s),
    .cin  (T_Z),
    .sum  (mac_sum_s),
    .cout (mac_cout_s)
  );

  assign unused_s      = ^mac_cout_s;
  assign mul_hi_next_s = mac_sum_s[PW-1:2*TPC];

  // Finished low trits shift in from the top of lo_r
  if (TPC < N_TRITS) begin : g_lo_shift
    assign mul_lo_next_s = {mac_sum_s[2*TPC-1:0], lo_r[W-1:2*TPC]};
  end else begin : g_lo_direct
    assign mul_lo_next_s = mac_sum_s[W-1:0];
  end

  assign last_step_s = (step_r == STEP_W'(S - 1));

  // Select the value loaded into the output registers when EXEC completes
  always_comb begin
    fin_lo_s    = '0;
    fin_hi_s    = '0;
    fin_carry_s = T_Z;
    fin_err_s   = bad_r;
    case (op_r)
      OP_ADD, OP_SUB: begin
        fin_lo_s    = add_sum_s;
        fin_carry_s = add_cout_s;
      end
      OP_MUL: begin
        fin_lo_s = mul_lo_next_s;
        fin_hi_s = mul_hi_next_s;
      end
      OP_TMUL, OP_MIN, OP_MAX: begin
        fin_lo_s = tw_s;
      end
      default: begin
        fin_err_s = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: MUL stays in EXEC for S cycles, everything else for one
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if ((op_r != OP_MUL) || last_step_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, multiply iteration and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r      <= '0;
      op_r        <= 3'b000;
      a_r         <= '0;
      b_r         <= '0;
      bad_r       <= 1'b0;
      acc_r       <= '0;
      lo_r        <= '0;
      out_valid_r <= 1'b0;
      result_lo_r <= '0;
      result_hi_r <= '0;
      carry_r     <= T_Z;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r   <= op;
            a_r    <= a_clean_s;
            b_r    <= b_clean_s;
            bad_r  <= in_bad_s | op_bad_s;
            acc_r  <= '0;
            lo_r   <= '0;
            step_r <= '0;
          end
        end
        ST_EXEC: begin
          if (op_r == OP_MUL) begin
            acc_r  <= mul_hi_next_s;
            lo_r   <= mul_lo_next_s;
            b_r    <= b_r >> (2 * TPC);
            step_r <= step_r + STEP_W'(1);
          end
          if (state_s == ST_DONE) begin
            result_lo_r <= fin_lo_s;
            result_hi_r <= fin_hi_s;
            carry_r     <= fin_carry_s;
            err_r       <= fin_err_s;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rst_n & (state_r == ST_IDLE);
  assign out_valid = out_valid_r;
  assign result_lo = result_lo_r;
  assign result_hi = result_hi_r;
  assign carry     = carry_r;
  assign err       = err_r;

endmodule

// File: tb/tb_ternary_seq_alu.sv
// Randomised and directed bench for ternary_seq_alu against an integer-arithmetic reference model.
module tb_ternary_seq_alu;

  localparam int     N = 9;
  localparam int     W = 2 * N;
  localparam longint H = 9841;
  localparam longint M = 19683;

  localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_MUL = 3'b010;
  localparam logic [2:0] C_TMUL = 3'b011, C_MIN = 3'b100, C_MAX = 3'b101;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, err, in_ready3, out_valid3, err3;
  logic [W-1:0] result_lo, result_hi, result_lo3, result_hi3;
  logic [1:0]   carry, carry3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [1:0]   cy;
    logic         er;
  } exp_t;

  ternary_seq_alu #(.N_TRITS(N), .TPC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .carry(carry), .err(err)
  );

  ternary_seq_alu #(.N_TRITS(N), .TPC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .op(op),
    .a(a), .b(b), .out_valid(out_valid3), .out_ready(out_ready3),
    .result_lo(result_lo3), .result_hi(result_hi3), .carry(carry3), .err(err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int tv(input logic [1:0] t);
    if (t == 2'b01) return 1;
    else if (t == 2'b10) return -1;
    else return 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    if (v > 0) return 2'b01;
    else if (v < 0) return 2'b10;
    else return 2'b00;
  endfunction

  // Integer to 2N-trit balanced ternary
  function automatic logic [2*W-1:0] to_bt(input longint v);
    logic [2*W-1:0] r;
    longint x, d;
    r = '0;
    x = v;
    for (int i = 0; i < 2 * N; i++) begin
      d = ((x % 3) + 3) % 3;
      if (d == 2) begin
        r[2*i +: 2] = 2'b10;
        x = (x + 1) / 3;
      end else begin
        r[2*i +: 2] = (d == 1) ? 2'b01 : 2'b00;
        x = (x - d) / 3;
      end
    end
    return r;
  endfunction

  function automatic longint from_bt(input logic [W-1:0] w);
    longint v, wgt;
    v = 0;
    wgt = 1;
    for (int i = 0; i < N; i++) begin
      v = v + tv(w[2*i +: 2]) * wgt;
      wgt = wgt * 3;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] enc9(input longint v);
    logic [2*W-1:0] t;
    t = to_bt(v);
    return t[W-1:0];
  endfunction

  function automatic logic has11(input logic [W-1:0] w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++) r = r | (w[2*i +: 2] == 2'b11);
    return r;
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    longint x, y, s, wv;
    logic [2*W-1:0] p;
    int pi, qi, ri;
    x = from_bt(av);
    y = from_bt(bv);
    e = '0;
    e.er = has11(av) | has11(bv) | (o > 3'd5);
    case (o)
      C_ADD, C_SUB: begin
        s = (o == C_ADD) ? x + y : x - y;
        wv = s;
        if (wv > H) wv = wv - M;
        else if (wv < -H) wv = wv + M;
        e.lo = enc9(wv);
        e.cy = enc(int'((s - wv) / M));
      end
      C_MUL: begin
        p = to_bt(x * y);
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
      end
      C_TMUL, C_MIN, C_MAX: begin
        for (int i = 0; i < N; i++) begin
          pi = tv(av[2*i +: 2]);
          qi = tv(bv[2*i +: 2]);
          if (o == C_TMUL) ri = pi * qi;
          else if (o == C_MIN) ri = (pi < qi) ? pi : qi;
          else ri = (pi > qi) ? pi : qi;
          e.lo[2*i +: 2] = enc(ri);
        end
      end
      default: e.er = 1'b1;
    endcase
    return e;
  endfunction

  task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int hold);
    exp_t e;
    int k;
    e = model(o, av, bv);
    @(negedge clk);
    check({nm, "_rdy"}, in_ready, 1);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    check({nm, "_busy"}, in_ready, 0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, "_lat"}, k, (o == C_MUL) ? 9 : 1);
    check({nm, "_lo"}, result_lo, e.lo);
    check({nm, "_hi"}, result_hi, e.hi);
    check({nm, "_cy"}, carry, e.cy);
    check({nm, "_err"}, err, e.er);
    check({nm, "_drdy"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1; op = C_ADD; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check({nm, "_hold_lo"}, result_lo, e.lo);
      check({nm, "_hold_hi"}, result_hi, e.hi);
      check({nm, "_hold_vld"}, out_valid, 1);
      check({nm, "_hold_rdy"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_ovld_off"}, out_valid, 0);
    check({nm, "_idle"}, in_ready, 1);
  endtask

  task automatic run_mul3(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int k;
    e = model(C_MUL, av, bv);
    @(negedge clk);
    op = C_MUL; a = av; b = bv; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    k = 0;
    while (!out_valid3 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, "_lat"}, k, 3);
    check({nm, "_lo"}, result_lo3, e.lo);
    check({nm, "_hi"}, result_hi3, e.hi);
    @(negedge clk);
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
    check({nm, "_ovld_off"}, out_valid3, 0);
  endtask

  logic [W-1:0] pa, pb, ra, rb;
  logic [2:0]   ro;
  int           idx;

  initial begin
    #1;
    check("rst_in_ready_low", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_carry", carry, 0);
    check("rst_err", err, 0);

    run_op("add13", C_ADD, enc9(13), enc9(1), 0);
    run_op("add_wrap", C_ADD, enc9(9841), enc9(1), 0);
    run_op("sub_wrap", C_SUB, enc9(-9841), enc9(1), 0);
    run_op("mul_max", C_MUL, enc9(9841), enc9(9841), 5);
    run_op("mul_neg", C_MUL, enc9(-1), enc9(5), 0);

    // Reset in the middle of a multiply, with no clock edge before sampling
    @(negedge clk);
    op = C_MUL; a = enc9(1234); b = enc9(-567); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_vld", out_valid, 0);
    check("midrst_lo", result_lo, 0);
    check("midrst_hi", result_hi, 0);
    check("midrst_rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rdy_after", in_ready, 1);
    run_op("add2", C_ADD, enc9(2), enc9(2), 0);

    pa = enc9(5);
    pa[7:6] = 2'b11;
    run_op("add_ill", C_ADD, pa, enc9(3), 0);
    run_op("op7", 3'b111, enc9(100), enc9(7), 0);

    for (int i = 0; i < N; i++) begin
      idx = (N - 1 - i) % 3;
      pa[2*i +: 2] = (idx == 0) ? 2'b01 : (idx == 1) ? 2'b00 : 2'b10;
      pb[2*i +: 2] = (idx == 0) ? 2'b10 : (idx == 1) ? 2'b01 : 2'b10;
    end
    run_op("tmul", C_TMUL, pa, pb, 0);
    run_op("min", C_MIN, pa, pb, 0);
    run_op("max", C_MAX, pa, pb, 0);

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(7, 0));
      ra = enc9(longint'($urandom_range(19682, 0)) - H);
      rb = enc9(longint'($urandom_range(19682, 0)) - H);
      if ($urandom_range(7, 0) == 0) begin
        idx = $urandom_range(N - 1, 0);
        ra[2*idx +: 2] = 2'b11;
      end
      run_op("rnd", ro, ra, rb, 0);
    end

    run_mul3("mul3_max", enc9(9841), enc9(9841));
    run_mul3("mul3_neg", enc9(-1), enc9(5));
    run_mul3("mul3_mix", enc9(-4321), enc9(777));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
